// File: rtl/des_iter_ctrl_if.sv
// Handshake and datapath-control bundle between a DES block requester/consumer
// and the iterative round sequencer.
interface des_iter_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic             decrypt;
    logic             load_en;
    logic             round_en;
    logic [3:0]       round_idx;
    logic [3:0]       subkey_idx;
    logic             final_en;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] blocks_done;

    // Requester/consumer side.
    modport master (
        output in_valid, decrypt, out_ready,
        input  in_ready, load_en, round_en, round_idx, subkey_idx,
               final_en, out_valid, busy, blocks_done
    );

    // Sequencer side.
    modport slave (
        input  in_valid, decrypt, out_ready,
        output in_ready, load_en, round_en, round_idx, subkey_idx,
               final_en, out_valid, busy, blocks_done
    );
endinterface

// File: rtl/des_iter_ctrl.sv
// Sequencer for an iterative DES engine: one shared Feistel round unit, strobes
// for load / round / final capture, subkey ordering and a completed-block count.
module des_iter_ctrl #(
    parameter int NUM_ROUNDS   = 16,
    parameter int ROUND_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input logic          clk,
    input logic          reset,
    des_iter_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic [2:0] LAST_CYC   = 3'(ROUND_CYCLES - 1);

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [3:0]       round_q, round_d;
    logic [2:0]       cyc_q, cyc_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic in_ready, load_en, round_en, final_en, out_valid, busy;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            round_q <= '0;
            cyc_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            round_q <= round_d;
            cyc_q   <= cyc_d;
            count_q <= count_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        round_d   = round_q;
        cyc_d     = cyc_q;
        count_d   = count_q;
        in_ready  = 1'b0;
        load_en   = 1'b0;
        round_en  = 1'b0;
        final_en  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;

        unique case (state_q)
            IDLE: begin
                busy     = 1'b0;
                // Reset must win over a simultaneous request.
                in_ready = !reset;
                if (bus.in_valid && in_ready) begin
                    mode_d  = bus.decrypt;
                    round_d = '0;
                    cyc_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_en = 1'b1;
                state_d = ROUND;
            end
            ROUND: begin
                if (cyc_q == LAST_CYC) begin
                    round_en = 1'b1;
                    cyc_d    = '0;
                    if (round_q == LAST_ROUND) begin
                        state_d = FINAL;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 3'd1;
                end
            end
            FINAL: begin
                final_en = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decryption walks the key schedule backwards.
    assign bus.subkey_idx  = mode_q ? (LAST_ROUND - round_q) : round_q;
    assign bus.round_idx   = round_q;
    assign bus.in_ready    = in_ready;
    assign bus.load_en     = load_en;
    assign bus.round_en    = round_en;
    assign bus.final_en    = final_en;
    assign bus.out_valid   = out_valid;
    assign bus.busy        = busy;
    assign bus.blocks_done = count_q;
endmodule

// File: tb/tb_des_iter_ctrl.sv
// Directed bench for des_iter_ctrl: a default instance (16 rounds, 1 cycle) and
// a multicycle instance (3 cycles/round, 2-bit counter), each tracked by a model.
module tb_des_iter_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    des_iter_ctrl_if #(.CNT_W(16)) ba ();
    des_iter_ctrl_if #(.CNT_W(2))  bb ();

    des_iter_ctrl #(.NUM_ROUNDS(16), .ROUND_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ba)
    );
    des_iter_ctrl #(.NUM_ROUNDS(16), .ROUND_CYCLES(3), .CNT_W(2)) dut_b (
        .clk(clk), .reset(rst_b), .bus(bb)
    );

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: each block is described by k = edges since acceptance (k=1 is the
    // load cycle), from which every strobe and index follows arithmetically.
    bit m_live[2];
    bit m_active[2];
    bit m_mode[2];
    int m_k[2];
    int m_count[2];
    int m_nr[2]  = '{16, 16};
    int m_rc[2]  = '{1, 3};
    int m_mod[2] = '{65536, 4};

    task automatic model_step(input int id, input logic rst, input logic iv,
                              input logic dec, input logic ordy);
        int done_k;
        done_k = m_nr[id] * m_rc[id] + 3;
        if (rst) begin
            m_live[id]   = 1'b1;
            m_active[id] = 1'b0;
            m_k[id]      = 0;
            m_count[id]  = 0;
        end else if (!m_active[id]) begin
            if (iv) begin
                m_active[id] = 1'b1;
                m_k[id]      = 1;
                m_mode[id]   = dec;
            end
        end else if (m_k[id] >= done_k && ordy) begin
            m_active[id] = 1'b0;
            m_count[id]  = (m_count[id] + 1) % m_mod[id];
        end else if (m_k[id] < done_k) begin
            m_k[id]++;
        end
    endtask

    task automatic model_compare(input int id, input logic rst, input logic rdy,
                                 input logic bsy, input logic ld, input logic re,
                                 input logic fe, input logic ov, input logic [3:0] ri,
                                 input logic [3:0] ski, input logic [31:0] bd);
        string pfx;
        int    nr, rc, nrc, k, ri_e;
        bit    act, in_round;
        if (!m_live[id]) return;
        pfx      = (id == 0) ? "a" : "b";
        nr       = m_nr[id];
        rc       = m_rc[id];
        nrc      = nr * rc;
        k        = m_k[id];
        act      = m_active[id];
        in_round = act && k >= 2 && k <= nrc + 1;
        check({pfx, ".in_ready"},    rdy, !act && !rst);
        check({pfx, ".busy"},        bsy, act);
        check({pfx, ".load_en"},     ld,  act && k == 1);
        check({pfx, ".round_en"},    re,  in_round && ((k - 2) % rc == rc - 1));
        check({pfx, ".final_en"},    fe,  act && k == nrc + 2);
        check({pfx, ".out_valid"},   ov,  act && k >= nrc + 3);
        check({pfx, ".blocks_done"}, bd,  m_count[id]);
        if (act && k <= nrc + 2) begin
            ri_e = (k == 1) ? 0 : (in_round ? (k - 2) / rc : nr - 1);
            check({pfx, ".round_idx"},  ri,  ri_e);
            check({pfx, ".subkey_idx"}, ski, m_mode[id] ? nr - 1 - ri_e : ri_e);
        end
    endtask

    always @(posedge clk) model_step(0, rst_a, ba.in_valid, ba.decrypt, ba.out_ready);
    always @(posedge clk) model_step(1, rst_b, bb.in_valid, bb.decrypt, bb.out_ready);

    always @(negedge clk)
        model_compare(0, rst_a, ba.in_ready, ba.busy, ba.load_en, ba.round_en, ba.final_en,
                      ba.out_valid, ba.round_idx, ba.subkey_idx, 32'(ba.blocks_done));
    always @(negedge clk)
        model_compare(1, rst_b, bb.in_ready, bb.busy, bb.load_en, bb.round_en, bb.final_en,
                      bb.out_valid, bb.round_idx, bb.subkey_idx, 32'(bb.blocks_done));

    // Instance A helpers; times are in sampling-edge numbers (acceptance edge T).
    int         a_nld, a_nfe;
    logic [3:0] a_sk[$];

    task automatic req_a(input bit dec, output int t_acc);
        @(posedge clk);
        #1 ba.in_valid = 1'b1;
        ba.decrypt = dec;
        t_acc = -1;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (ba.in_ready) begin
                t_acc = cyc + 1;
                break;
            end
        end
        check("a.accepted", t_acc >= 0, 1);
        @(posedge clk);
        #1 ba.in_valid = 1'b0;
    endtask

    task automatic wait_ov_a(input bit toggle, output int t_ov);
        a_nld = 0;
        a_nfe = 0;
        a_sk.delete();
        t_ov = -1;
        for (int j = 0; j < 300; j++) begin
            @(negedge clk);
            if (ba.load_en)  a_nld++;
            if (ba.final_en) a_nfe++;
            if (ba.round_en) a_sk.push_back(ba.subkey_idx);
            if (ba.out_valid) begin
                t_ov = cyc + 1;
                break;
            end
            if (toggle) begin
                @(posedge clk);
                #1 ba.decrypt = ~ba.decrypt;
            end
        end
        check("a.out_valid_seen", t_ov >= 0, 1);
    endtask

    task automatic check_pulses_a(input int first_sk, input int last_sk);
        check("a.load_pulses",  a_nld, 1);
        check("a.final_pulses", a_nfe, 1);
        check("a.round_pulses", a_sk.size(), 16);
        if (a_sk.size() == 16) begin
            check("a.first_subkey", a_sk[0], first_sk);
            check("a.last_subkey",  a_sk[15], last_sk);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t_acc, t_ov, ov_seen;
        bit found;
        int t_prev, n_re;
        int exp_bd[5];
        exp_bd = '{1, 2, 3, 0, 1};

        rst_a = 1'b1; ba.in_valid = 1'b0; ba.decrypt = 1'b0; ba.out_ready = 1'b1;
        rst_b = 1'b1; bb.in_valid = 1'b0; bb.decrypt = 1'b0; bb.out_ready = 1'b1;

        fork
            begin : seq_a
                repeat (3) @(posedge clk);
                #1 rst_a = 1'b0;
                @(negedge clk);
                check("a.reset_in_ready",    ba.in_ready, 1);
                check("a.reset_busy",        ba.busy, 0);
                check("a.reset_round_idx",   ba.round_idx, 0);
                check("a.reset_blocks_done", ba.blocks_done, 0);

                // Encrypt block, consumer always ready.
                req_a(1'b0, t_acc);
                wait_ov_a(1'b0, t_ov);
                check("a.latency_enc", t_ov - t_acc, 19);
                check_pulses_a(0, 15);
                @(negedge clk);
                check("a.blocks_done_1", ba.blocks_done, 1);

                // Decrypt block with the mode input toggling after acceptance.
                req_a(1'b1, t_acc);
                wait_ov_a(1'b1, t_ov);
                check("a.latency_dec", t_ov - t_acc, 19);
                check_pulses_a(15, 0);
                @(negedge clk);
                check("a.blocks_done_2", ba.blocks_done, 2);

                // Backpressure with a pending request.
                @(posedge clk);
                #1 ba.out_ready = 1'b0;
                req_a(1'b0, t_acc);
                wait_ov_a(1'b0, t_ov);
                @(posedge clk);
                #1 ba.in_valid = 1'b1;
                repeat (10) begin
                    @(negedge clk);
                    check("a.bp_out_valid", ba.out_valid, 1);
                    check("a.bp_in_ready",  ba.in_ready, 0);
                end
                @(posedge clk);
                #1 ba.out_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                check("a.bp_idle_in_ready", ba.in_ready, 1);
                check("a.blocks_done_3",    ba.blocks_done, 3);
                t_acc = cyc + 1;
                @(posedge clk);
                #1 ba.in_valid = 1'b0;
                wait_ov_a(1'b0, t_ov);
                check("a.latency_pending", t_ov - t_acc, 19);
                @(negedge clk);
                check("a.blocks_done_4", ba.blocks_done, 4);

                // Reset in the middle of round 7.
                req_a(1'b0, t_acc);
                found = 1'b0;
                for (int j = 0; j < 60; j++) begin
                    @(negedge clk);
                    if (ba.busy && !ba.load_en && ba.round_idx == 4'd7) begin
                        found = 1'b1;
                        break;
                    end
                end
                check("a.reached_round7", found, 1);
                #1 rst_a = 1'b1;
                @(posedge clk);
                #1 rst_a = 1'b0;
                @(negedge clk);
                check("a.mid_busy",        ba.busy, 0);
                check("a.mid_round_en",    ba.round_en, 0);
                check("a.mid_final_en",    ba.final_en, 0);
                check("a.mid_out_valid",   ba.out_valid, 0);
                check("a.mid_round_idx",   ba.round_idx, 0);
                check("a.mid_in_ready",    ba.in_ready, 1);
                ov_seen = 0;
                repeat (40) begin
                    @(negedge clk);
                    if (ba.out_valid) ov_seen++;
                end
                check("a.mid_no_out_valid", ov_seen, 0);
                check("a.mid_blocks_done",  ba.blocks_done, 0);
            end
            begin : seq_b
                repeat (3) @(posedge clk);
                #1 rst_b = 1'b0;
                bb.in_valid = 1'b1;
                @(negedge clk);
                t_prev = -1;
                for (int i = 0; i < 5; i++) begin
                    int b_acc, b_ov;
                    b_acc = -1;
                    b_ov  = -1;
                    n_re  = 0;
                    for (int j = 0; j < 100; j++) begin
                        if (bb.in_ready) begin
                            b_acc = cyc + 1;
                            break;
                        end
                        @(negedge clk);
                    end
                    check("b.accepted", b_acc >= 0, 1);
                    if (i > 0) check("b.accept_spacing", b_acc - t_prev, 52);
                    t_prev = b_acc;
                    for (int j = 0; j < 200; j++) begin
                        @(negedge clk);
                        if (bb.round_en) n_re++;
                        if (bb.out_valid) begin
                            b_ov = cyc + 1;
                            break;
                        end
                    end
                    check("b.round_pulses", n_re, 16);
                    if (i == 0) check("b.latency", b_ov - b_acc, 51);
                    @(negedge clk);
                    check("b.blocks_done",       bb.blocks_done, exp_bd[i]);
                    check("b.in_ready_after_hs", bb.in_ready, 1);
                end
                #1 bb.in_valid = 1'b0;
                repeat (3) @(negedge clk);
            end
        join

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
